perf_monitor: RTL and testbench

Multi-channel performance monitor for the Hack CPU system, replacing the single cycle counter. It watches the CPU program counter and memory-write strobe and runs a run-control state machine that raises `finished` when the program reaches its final PC, which gates the CPU clock. It keeps up to eight saturating event counters and serves one of them, selected by `sel`, to the on-screen and 7-segment display logic.

---
 rtl/perf_monitor.sv | 166 ++++++++++++++++
 tb/tb_perf_monitor.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_monitor.sv
// perf_monitor: run-control FSM plus saturating event counters for the Hack CPU.
// Optional macro PERF_SNAPSHOT_EN builds shadow registers for a coherent display readout.
module perf_monitor #(
    parameter int unsigned PC_WIDTH     = 12,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter int unsigned FINAL_PC     = 4095,
    parameter int unsigned REGION_BASE  = 0,
    parameter int unsigned REGION_SPAN  = 512,
    parameter bit          AUTO_START   = 1'b1,
    localparam int unsigned SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                    CLK_50,
    input  logic                    resetN,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic                    pc_valid,
    input  logic                    write_m,
    input  logic                    start,
    input  logic                    snap,
    input  logic [SEL_W-1:0]        sel,
    output logic [COUNT_WIDTH-1:0]  count_out,
    output logic [NUM_CHANNELS-1:0] overflow,
    output logic                    running,
    output logic                    finished
);
    localparam int unsigned RW = PC_WIDTH + 4;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic                     clear_c;
    logic                     count_en_c;
    logic [NUM_CHANNELS-1:0]  ev_c;
    logic [COUNT_WIDTH-1:0]   cnt_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  ovf_q;
    logic [PC_WIDTH-1:0]      last_pc_q;
    logic                     have_last_q;
    logic [COUNT_WIDTH-1:0]   read_c;

    // Next state; clear_c marks every edge that (re)enters RUN.
    always_comb begin
        state_d = state_q;
        clear_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (AUTO_START || start) begin
                    state_d = RUN;
                    clear_c = 1'b1;
                end
            end
            RUN: begin
                if (start) begin
                    clear_c = 1'b1;
                end else if (pc_valid && (pc == PC_WIDTH'(FINAL_PC))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    clear_c = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign count_en_c = (state_q == RUN) && !start;

    // Per-channel event decode
    for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ev
        if (k == 0) begin : g_cycle
            assign ev_c[k] = 1'b1;
        end else if (k == 1) begin : g_retire
            assign ev_c[k] = pc_valid;
        end else if (k == 2) begin : g_write
            assign ev_c[k] = pc_valid && write_m;
        end else if (k == 3) begin : g_jump
            assign ev_c[k] = pc_valid && have_last_q &&
                             (pc != PC_WIDTH'(last_pc_q + PC_WIDTH'(1)));
        end else begin : g_region
            // Bounds are widened so the top region's upper limit cannot wrap to zero.
            localparam logic [RW-1:0] LO = RW'(REGION_BASE + (k - 4) * REGION_SPAN);
            localparam logic [RW-1:0] HI = RW'(REGION_BASE + (k - 3) * REGION_SPAN);
            assign ev_c[k] = pc_valid && (RW'(pc) >= LO) && (RW'(pc) < HI);
        end
    end

    // Saturating counters, sticky overflow and last retired PC
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CHANNELS; i++) cnt_q[i] <= '0;
            ovf_q       <= '0;
            last_pc_q   <= '0;
            have_last_q <= 1'b0;
        end else if (clear_c) begin
            for (int i = 0; i < NUM_CHANNELS; i++) cnt_q[i] <= '0;
            ovf_q       <= '0;
            have_last_q <= 1'b0;
        end else if (count_en_c) begin
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (ev_c[i]) begin
                    if (&cnt_q[i]) ovf_q[i] <= 1'b1;
                    else           cnt_q[i] <= cnt_q[i] + COUNT_WIDTH'(1);
                end
            end
            if (pc_valid) begin
                last_pc_q   <= pc;
                have_last_q <= 1'b1;
            end
        end
    end

`ifdef PERF_SNAPSHOT_EN
    logic [COUNT_WIDTH-1:0]  shadow_q [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] shadow_ovf_q;

    // Shadows capture pre-edge values, so a snap alongside start keeps the old run.
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= '0;
            shadow_ovf_q <= '0;
        end else if (snap) begin
            for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= cnt_q[i];
            shadow_ovf_q <= ovf_q;
        end
    end

    always_comb begin
        read_c = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel == SEL_W'(i)) read_c = shadow_q[i];
        end
    end

    assign overflow = shadow_ovf_q;
`else
    logic unused_snap;
    assign unused_snap = snap;

    always_comb begin
        read_c = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (sel == SEL_W'(i)) read_c = cnt_q[i];
        end
    end

    assign overflow = ovf_q;
`endif

    // State register and registered outputs
    always_ff @(posedge CLK_50 or negedge resetN) begin
        if (!resetN) begin
            state_q   <= IDLE;
            running   <= 1'b0;
            finished  <= 1'b0;
            count_out <= '0;
        end else begin
            state_q   <= state_d;
            running   <= (state_d == RUN);
            finished  <= (state_d == DONE);
            count_out <= read_c;
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor: directed vector bench for perf_monitor with a second,
// narrow-counter instance sharing the stimulus to exercise saturation.
module tb_perf_monitor;
    logic        clk;
    logic        rst_n;
    logic [11:0] pc;
    logic        pc_valid;
    logic        write_m;
    logic        start;
    logic        snap;
    logic [2:0]  sel;
    logic [31:0] count_out;
    logic [4:0]  overflow;
    logic        running;
    logic        finished;
    logic [3:0]  sat_count;
    logic [4:0]  sat_ovf;
    logic        sat_running;
    logic        sat_finished;

    int checks = 0;
    int errors = 0;

    perf_monitor #(.NUM_CHANNELS(5)) dut (
        .CLK_50(clk), .resetN(rst_n), .pc(pc), .pc_valid(pc_valid),
        .write_m(write_m), .start(start), .snap(snap), .sel(sel),
        .count_out(count_out), .overflow(overflow),
        .running(running), .finished(finished)
    );

    perf_monitor #(.NUM_CHANNELS(5), .COUNT_WIDTH(4)) dut_sat (
        .CLK_50(clk), .resetN(rst_n), .pc(pc), .pc_valid(pc_valid),
        .write_m(write_m), .start(start), .snap(snap), .sel(sel),
        .count_out(sat_count), .overflow(sat_ovf),
        .running(sat_running), .finished(sat_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    typedef struct {
        logic        pv;
        logic [11:0] pc;
        logic        wm;
        logic [2:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    initial begin
        // Retirements 0,1,2,10,11,2,511,512 then readout; exp is count_out after the edge.
        vecs[0]  = '{1'b1, 12'd0,   1'b0, 3'd0, 32'd0};
        vecs[1]  = '{1'b1, 12'd1,   1'b1, 3'd0, 32'd1};
        vecs[2]  = '{1'b1, 12'd2,   1'b0, 3'd0, 32'd2};
        vecs[3]  = '{1'b1, 12'd10,  1'b0, 3'd0, 32'd3};
        vecs[4]  = '{1'b1, 12'd11,  1'b1, 3'd0, 32'd4};
        vecs[5]  = '{1'b1, 12'd2,   1'b0, 3'd0, 32'd5};
        vecs[6]  = '{1'b1, 12'd511, 1'b0, 3'd0, 32'd6};
        vecs[7]  = '{1'b1, 12'd512, 1'b0, 3'd0, 32'd7};
        vecs[8]  = '{1'b0, 12'd0,   1'b0, 3'd1, 32'd8};
        vecs[9]  = '{1'b0, 12'd0,   1'b0, 3'd2, 32'd2};
        vecs[10] = '{1'b0, 12'd0,   1'b0, 3'd3, 32'd3};
        vecs[11] = '{1'b0, 12'd0,   1'b0, 3'd7, 32'd0};
        vecs[12] = '{1'b0, 12'd0,   1'b0, 3'd4, 32'd7};
        vecs[13] = '{1'b0, 12'd0,   1'b0, 3'd0, 32'd13};

        rst_n = 1'b1; pc = '0; pc_valid = 1'b0; write_m = 1'b0;
        start = 1'b0; snap = 1'b0; sel = '0;
        #1 rst_n = 1'b0;
        #2;
        check("reset count_out", count_out, 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset running", 32'(running), 32'd0);
        check("reset finished", 32'(finished), 32'd0);
        tick();
        tick();
        check("held reset running", 32'(running), 32'd0);
        rst_n = 1'b1;
        tick();
        check("autostart running", 32'(running), 32'd1);
        check("autostart finished", 32'(finished), 32'd0);

`ifndef PERF_SNAPSHOT_EN
        // Memory writes, jumps, region bounds and readout latency
        for (int i = 0; i < 14; i++) begin
            pc_valid = vecs[i].pv;
            pc       = vecs[i].pc;
            write_m  = vecs[i].wm;
            sel      = vecs[i].sel;
            tick();
            check($sformatf("vec%0d count_out", i), count_out, vecs[i].exp);
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'd0);
            check($sformatf("vec%0d running", i), 32'(running), 32'd1);
        end

        // Narrow instance: 20 cycles in RUN saturate ch0 only
        pc_valid = 1'b0; write_m = 1'b0; sel = 3'd0;
        repeat (6) tick();
        check("sat ch0", 32'(sat_count), 32'd15);
        check("sat overflow", 32'(sat_ovf), 32'd1);
        sel = 3'd1;
        tick();
        check("sat ch1", 32'(sat_count), 32'd8);
        check("sat overflow ch1 clean", 32'(sat_ovf), 32'd1);
        check("wide overflow clean", 32'(overflow), 32'd0);

        // Restart then full run to FINAL_PC
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart running", 32'(running), 32'd1);
        check("restart sat overflow cleared", 32'(sat_ovf), 32'd0);
        for (int p = 0; p < 4096; p++) begin
            pc_valid = 1'b1;
            pc       = 12'(p);
            tick();
            if (p == 4094) check("not yet finished", 32'(finished), 32'd0);
        end
        pc_valid = 1'b0; pc = '0;
        check("run finished", 32'(finished), 32'd1);
        check("run not running", 32'(running), 32'd0);
        sel = 3'd0; tick(); check("full ch0", count_out, 32'd4096);
        sel = 3'd1; tick(); check("full ch1", count_out, 32'd4096);
        sel = 3'd2; tick(); check("full ch2", count_out, 32'd0);
        sel = 3'd3; tick(); check("full ch3", count_out, 32'd0);
        sel = 3'd4; tick(); check("full ch4", count_out, 32'd512);
        repeat (5) tick();
        sel = 3'd0; tick(); check("frozen ch0", count_out, 32'd4096);
        check("done holds", 32'(finished), 32'd1);
        check("sat run overflow", 32'(sat_ovf), 32'b10011);

        // DONE -> RUN on start, then start beats the FINAL_PC match
        start = 1'b1;
        tick();
        check("done restart running", 32'(running), 32'd1);
        check("done restart finished", 32'(finished), 32'd0);
        pc_valid = 1'b1; pc = 12'd4095;
        tick();
        check("priority running", 32'(running), 32'd1);
        check("priority finished", 32'(finished), 32'd0);
        start = 1'b0; pc_valid = 1'b0; pc = '0; sel = 3'd0;
        tick();
        check("priority ch0 clear", count_out, 32'd0);
        check("priority overflow", 32'(overflow), 32'd0);
        sel = 3'd1;
        tick();
        check("priority ch1 clear", count_out, 32'd0);

        // Asynchronous reset mid-run
        sel = 3'd0;
        repeat (20) tick();
        check("prereset ch0", count_out, 32'd21);
        check("prereset sat overflow", 32'(sat_ovf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async count_out", count_out, 32'd0);
        check("async overflow", 32'(overflow), 32'd0);
        check("async running", 32'(running), 32'd0);
        check("async finished", 32'(finished), 32'd0);
        check("async sat overflow", 32'(sat_ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rerun running", 32'(running), 32'd1);
        tick();
        check("rerun ch0 zero", count_out, 32'd0);
        tick();
        check("rerun ch0 one", count_out, 32'd1);
`else
        // Snapshot holds the display while live counters move on
        sel = 3'd0;
        repeat (100) tick();
        snap = 1'b1;
        tick();
        snap = 1'b0;
        tick();
        check("snap ch0", count_out, 32'd100);
        repeat (50) tick();
        check("snap ch0 held", count_out, 32'd100);
        check("snap overflow", 32'(overflow), 32'd0);
        snap = 1'b1; start = 1'b1;
        tick();
        snap = 1'b0; start = 1'b0;
        tick();
        check("snap preclear", count_out, 32'd152);
        check("snap running", 32'(running), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
